// File: rtl/lab6_2_sw_ctrl.sv
// Stopwatch control sequencer: conditions start/stop and lap/clear buttons,
// runs the IDLE/RUN/LAP/PAUSE mode machine and drives counter/display controls.
module lab6_2_sw_ctrl #(
  parameter int DB_LEN = 100000,
  parameter int DB_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [1:0] state,
  output logic       run_led
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LEN - 1);

  // Bit 0 carries start/stop, bit 1 carries lap/clear through the whole chain.
  logic [1:0]      w_btn_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_d;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];
  logic            w_ss_p;
  logic            w_lap_p;
  state_t          r_state;
  logic            r_lap_hold;
  logic            r_cnt_clr;

  assign w_btn_raw = {btn_lap, btn_ss};

  // Two-stage synchronizer for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: a level must differ for DB_LEN consecutive cycles to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db        <= 2'b00;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Rising-edge detector producing one-cycle press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_d  <= 2'b00;
      r_press <= 2'b00;
    end else begin
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
    end
  end

  // Start/stop wins when both presses land in the same cycle.
  assign w_ss_p  = r_press[0];
  assign w_lap_p = r_press[1] & ~r_press[0];

  // Mode machine with registered lap_hold and cnt_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lap_hold <= 1'b0;
      r_cnt_clr  <= 1'b0;
    end else begin
      r_cnt_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_p) begin
            r_state    <= ST_RUN;
            r_lap_hold <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_ss_p) begin
            r_state    <= ST_PAUSE;
            r_lap_hold <= 1'b0;
          end else if (w_lap_p) begin
            r_state    <= ST_LAP;
            r_lap_hold <= 1'b1;
          end
        end
        ST_LAP: begin
          if (w_ss_p) begin
            r_state    <= ST_PAUSE;
            r_lap_hold <= 1'b0;
          end else if (w_lap_p) begin
            r_state    <= ST_RUN;
            r_lap_hold <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (w_ss_p) begin
            r_state    <= ST_RUN;
            r_lap_hold <= 1'b0;
          end else if (w_lap_p) begin
            r_state    <= ST_IDLE;
            r_lap_hold <= 1'b0;
            r_cnt_clr  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lap_hold <= 1'b0;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign run_led  = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign cnt_en   = tick_1hz & run_led;
  assign cnt_clr  = r_cnt_clr;
  assign lap_hold = r_lap_hold;

endmodule

// File: tb/tb_lab6_2_sw_ctrl.sv
// Directed bench for lab6_2_sw_ctrl with DB_LEN=4 (press visible 7 edges after first sampled-high edge).
module tb_lab6_2_sw_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       btn_ss;
  logic       btn_lap;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic [1:0] state;
  logic       run_led;

  int total = 0;
  int bad   = 0;
  int n_en  = 0;
  int n_clr = 0;
  int en_base;

  lab6_2_sw_ctrl #(.DB_LEN(4), .DB_W(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .btn_ss   (btn_ss),
    .btn_lap  (btn_lap),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_hold (lap_hold),
    .state    (state),
    .run_led  (run_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the active edge.
  always @(posedge clk) begin
    if (cnt_en === 1'b1) n_en <= n_en + 1;
    if (cnt_clr === 1'b1) n_clr <= n_clr + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_once(input logic exp_en);
    tick_1hz = 1'b1;
    #1;
    check("cnt_en_with_tick", {31'd0, cnt_en}, {31'd0, exp_en});
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic press(input logic is_lap, input logic [1:0] pre, input logic [1:0] post,
                       input logic hold, input logic clr);
    if (is_lap) btn_lap = 1'b1; else btn_ss = 1'b1;
    repeat (7) step();
    check("state_before_press", {30'd0, state}, {30'd0, pre});
    step();
    check("state_after_press", {30'd0, state}, {30'd0, post});
    check("lap_hold_after_press", {31'd0, lap_hold}, {31'd0, hold});
    check("cnt_clr_after_press", {31'd0, cnt_clr}, {31'd0, clr});
    step();
    check("cnt_clr_next_cycle", {31'd0, cnt_clr}, 32'd0);
    step();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) step();
    check("state_after_release", {30'd0, state}, {30'd0, post});
  endtask

  initial begin
    int k;
    int len;
    logic lvl;
    rst      = 1'b1;
    tick_1hz = 1'b0;
    btn_ss   = 1'b0;
    btn_lap  = 1'b0;
    step();

    // Reset with tick pulsing
    repeat (3) begin
      tick_1hz = 1'b1;
      #1;
      check("cnt_en_in_reset", {31'd0, cnt_en}, 32'd0);
      step();
      tick_1hz = 1'b0;
    end
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_lap_hold", {31'd0, lap_hold}, 32'd0);
    check("reset_run_led", {31'd0, run_led}, 32'd0);
    check("reset_cnt_clr", {31'd0, cnt_clr}, 32'd0);
    check("reset_en_pulses", n_en, 32'd0);
    rst = 1'b0;
    step();

    // Bounce rejection: runs of 1..3 cycles
    k   = 0;
    lvl = 1'b1;
    while (k < 40) begin
      len    = ((k * 7) % 3) + 1;
      btn_ss = lvl;
      repeat (len) step();
      k   = k + len;
      lvl = ~lvl;
    end
    btn_ss = 1'b0;
    repeat (10) step();
    check("bounce_state", {30'd0, state}, 32'd0);

    // Start and count
    press(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    check("run_led_run", {31'd0, run_led}, 32'd1);
    en_base = n_en;
    repeat (5) tick_once(1'b1);
    check("five_en_pulses", n_en - en_base, 32'd5);

    // Lap and release
    press(1'b1, 2'b01, 2'b10, 1'b1, 1'b0);
    check("run_led_lap", {31'd0, run_led}, 32'd1);
    tick_once(1'b1);
    press(1'b1, 2'b10, 2'b01, 1'b0, 1'b0);

    // Pause and clear
    press(1'b0, 2'b01, 2'b11, 1'b0, 1'b0);
    check("run_led_pause", {31'd0, run_led}, 32'd0);
    en_base = n_en;
    repeat (2) tick_once(1'b0);
    check("no_en_in_pause", n_en - en_base, 32'd0);
    press(1'b1, 2'b11, 2'b00, 1'b0, 1'b1);
    press(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick_once(1'b0);

    // Simultaneous presses in RUN: start/stop wins
    press(1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    btn_ss  = 1'b1;
    btn_lap = 1'b1;
    repeat (7) step();
    check("simul_pre", {30'd0, state}, 32'd1);
    step();
    check("simul_state", {30'd0, state}, 32'd3);
    check("simul_lap_hold", {31'd0, lap_hold}, 32'd0);
    step();
    check("simul_no_lap", {30'd0, state}, 32'd3);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (8) step();
    check("simul_after_release", {30'd0, state}, 32'd3);

    // Reset mid-debounce with button held through reset
    btn_ss = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
    rst = 1'b0;
    repeat (7) step();
    check("midrst_no_early_press", {30'd0, state}, 32'd0);
    step();
    check("midrst_press_after_stable", {30'd0, state}, 32'd1);
    btn_ss = 1'b0;
    repeat (8) step();

    check("total_en_pulses", n_en, 32'd6);
    check("total_clr_pulses", n_clr, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab6_2_sw_ctrl.md
Name: lab6_2_sw_ctrl

Overview:
Control sequencer for the stopwatch datapath (4-digit time counter plus 7-segment scan display). It conditions two raw push-buttons (start/stop, lap/clear), runs the stopwatch mode FSM, and issues count-enable, counter-clear and display-hold controls to the time counter and display blocks. It sits between the board buttons, the 1 Hz tick generator and the time counter.

Parameters:
DB_LEN, 100000, consecutive clk cycles a synchronized button level must be stable before the debounced level changes (bench overrides to 4)
DB_W, 17, width of the debounce counter (must hold DB_LEN)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-clk-wide pulse, once per second, from the tick generator
btn_ss  input  1  raw start/stop button, asynchronous, active-high
btn_lap  input  1  raw lap/clear button, asynchronous, active-high
cnt_en  output  1  count enable to the time counter; one-cycle pulse per counted second
cnt_clr  output  1  one-cycle synchronous clear to the time counter
lap_hold  output  1  display freeze; 1 = display keeps last latched digits
state  output  2  current mode: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE
run_led  output  1  1 while counting (RUN or LAP)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, cnt_en=0, cnt_clr=0, lap_hold=0, run_led=0; synchronizers, debounced levels, debounce counters and edge registers cleared to 0. Reset mid-operation aborts any pending press; a button held through reset produces a press only after it is observed stable high for DB_LEN cycles after reset is released.
- Per button: 2-FF synchronizer -> debouncer -> rising-edge detector.
- Debouncer: counter clears whenever the synchronized level equals the debounced level; otherwise it increments. When the count reaches DB_LEN-1 while still differing, the debounced level takes the synchronized value and the counter clears. Glitches shorter than DB_LEN cycles are ignored.
- Edge detector: registered press pulse, 1 cycle wide, on a debounced 0->1 transition only. No pulse on release.
- Latency: press pulse is high exactly DB_LEN+3 clk edges after the first edge that samples the raw button high. The FSM acts on the same edge.
- Press pulses: ss_p and lap_p. If both occur in the same cycle, ss_p is taken and lap_p is discarded.
- FSM transitions (all other cases hold state):
  IDLE: ss_p -> RUN.
  RUN: ss_p -> PAUSE; lap_p -> LAP.
  LAP: ss_p -> PAUSE; lap_p -> RUN.
  PAUSE: ss_p -> RUN; lap_p -> IDLE.
  In IDLE, lap_p is ignored.
- cnt_en = tick_1hz AND (state is RUN or LAP), combinational from the state register. A tick coinciding with a transition edge uses the pre-transition state.
- cnt_clr is registered. It is high for exactly the one cycle following the PAUSE->IDLE edge, which is the first cycle with state=IDLE. It is otherwise 0.
- lap_hold is registered and equals 1 exactly while state=LAP. It rises on the cycle state becomes LAP and falls on the cycle state leaves LAP.
- run_led is decoded from the state register.
- Tick count while paused or idle is 0: no cnt_en is ever emitted outside RUN/LAP.

Test Plan:
- Reset/idle: assert rst 3 cycles with tick_1hz pulsing -> all outputs 0, state=00, zero cnt_en pulses.
- Start and count (DB_LEN=4): btn_ss high 10 cycles from edge E -> state=01 from edge E+7; 5 subsequent tick pulses -> exactly 5 cnt_en pulses, each coincident with its tick.
- Bounce rejection: btn_ss toggled with high/low runs of 1-3 cycles for 40 cycles, then held low -> no press; state stays 00.
- Lap and release: in RUN press lap -> state=10, lap_hold=1, ticks still give cnt_en. Press lap again -> state=01, lap_hold=0.
- Pause/clear: RUN, press ss -> state=11, ticks give no cnt_en. Press lap -> state=00 with cnt_clr high exactly one cycle (first IDLE cycle). Press lap in IDLE -> no cnt_clr.
- Simultaneous/reset-mid-op: raw btn_ss and btn_lap rising on the same edge in RUN -> state=11 only, no LAP. Then assert rst while a button is mid-debounce -> state=00, no press after release of rst until DB_LEN stable cycles.
